// File: rtl/regbank_2r1w.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : regbank_2r1w
// Purpose  : Parameterised register bank, one write port, two registered
//            read ports (1-cycle latency), out-of-range write error pulse,
//            optional hard-wired zero register 0.
// Options  : REGBANK_BYPASS_EN - when defined, a read of the address being
//            written at the same edge returns the new data (write-first);
//            otherwise it returns the old contents (read-first).
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module regbank_2r1w #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int ZERO_R0 = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re_a,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]  rdata_a,
   output logic              rvalid_a,
   input  logic              re_b,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_b,
   output logic              rvalid_b,
   output logic              werr
);

   // One extra bit so that DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
   logic             rvalid_a_q, rvalid_a_d;
   logic             rvalid_b_q, rvalid_b_d;
   logic             werr_q, werr_d;

   logic             w_in_range;
   logic             w_wr_ok;
   logic             w_rd_ok_a;
   logic             w_rd_ok_b;
   logic [WIDTH-1:0] w_word_a;
   logic [WIDTH-1:0] w_word_b;

   // Address qualification: range checks and the hard-wired zero register.
   always_comb begin
      w_in_range = ({1'b0, waddr} < c_depth);
      w_wr_ok    = we && w_in_range && !((ZERO_R0 != 0) && (waddr == '0));
      w_rd_ok_a  = ({1'b0, raddr_a} < c_depth) && !((ZERO_R0 != 0) && (raddr_a == '0));
      w_rd_ok_b  = ({1'b0, raddr_b} < c_depth) && !((ZERO_R0 != 0) && (raddr_b == '0));
      werr_d     = we && !w_in_range;
   end

   // Next register contents: a single loop over DEPTH, so any size works.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_wr_ok && (waddr == ADDR_W'(i))) begin
            mem_d[i] = wdata;
         end
      end
   end

   // Read muxes for both ports, with optional same-edge write forwarding.
   always_comb begin
      w_word_a = '0;
      w_word_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr_a == ADDR_W'(i)) w_word_a = mem_q[i];
         if (raddr_b == ADDR_W'(i)) w_word_b = mem_q[i];
      end
`ifdef REGBANK_BYPASS_EN
      if (we && (waddr == raddr_a)) w_word_a = wdata;
      if (we && (waddr == raddr_b)) w_word_b = wdata;
`endif
      // Out-of-range and zero-register reads return 0 and win over forwarding.
      if (!w_rd_ok_a) w_word_a = '0;
      if (!w_rd_ok_b) w_word_b = '0;
   end

   // Output registers: capture on request, hold data otherwise; valid follows re.
   always_comb begin
      rdata_a_d  = re_a ? w_word_a : rdata_a_q;
      rdata_b_d  = re_b ? w_word_b : rdata_b_q;
      rvalid_a_d = re_a;
      rvalid_b_d = re_b;
   end

   // State update with asynchronous clear of every register and output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         werr_q     <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
         werr_q     <= werr_d;
      end
   end

   assign rdata_a  = rdata_a_q;
   assign rdata_b  = rdata_b_q;
   assign rvalid_a = rvalid_a_q;
   assign rvalid_b = rvalid_b_q;
   assign werr     = werr_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_2r1w.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_regbank_2r1w
// Purpose  : Self-checking bench for regbank_2r1w. Two instances share one
//            stimulus stream: index 0 uses default parameters, index 1 uses
//            DEPTH=12 and ZERO_R0=1. Honours REGBANK_BYPASS_EN.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_regbank_2r1w;

   logic        clk = 1'b0;
   logic        rst;
   logic        we, re_a, re_b;
   logic [3:0]  waddr, raddr_a, raddr_b;
   logic [31:0] wdata;

   logic [31:0] rda0, rdb0, rda1, rdb1;
   logic        rva0, rvb0, rva1, rvb1, werr0, werr1;

   logic [31:0] o_rda [2];
   logic [31:0] o_rdb [2];
   logic        o_rva [2];
   logic        o_rvb [2];
   logic        o_werr[2];

   int checks   = 0;
   int failures = 0;
   logic chk_on = 1'b0;

`ifdef REGBANK_BYPASS_EN
   localparam logic [31:0] C_COLL = 32'h22;
`else
   localparam logic [31:0] C_COLL = 32'h11;
`endif

   always #5 clk = ~clk;

   regbank_2r1w #(.WIDTH(32), .DEPTH(16), .ADDR_W(4), .ZERO_R0(0)) u_dut0 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda0), .rvalid_a(rva0),
      .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb0), .rvalid_b(rvb0),
      .werr(werr0)
   );

   regbank_2r1w #(.WIDTH(32), .DEPTH(12), .ADDR_W(4), .ZERO_R0(1)) u_dut1 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda1), .rvalid_a(rva1),
      .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb1), .rvalid_b(rvb1),
      .werr(werr1)
   );

   assign o_rda[0] = rda0;  assign o_rda[1] = rda1;
   assign o_rdb[0] = rdb0;  assign o_rdb[1] = rdb1;
   assign o_rva[0] = rva0;  assign o_rva[1] = rva1;
   assign o_rvb[0] = rvb0;  assign o_rvb[1] = rvb1;
   assign o_werr[0] = werr0; assign o_werr[1] = werr1;

   // ---------------- behavioural model ----------------
   int          dep [2] = '{16, 12};
   int          zr  [2] = '{0, 1};
   logic [31:0] mdl [2][16];
   logic [31:0] e_rda [2];
   logic [31:0] e_rdb [2];
   logic        e_rva [2];
   logic        e_rvb [2];
   logic        e_werr[2];

   function automatic logic [31:0] mread(int k, logic [3:0] a);
      if (int'(a) >= dep[k]) return 32'h0;
      if (zr[k] != 0 && a == 4'd0) return 32'h0;
`ifdef REGBANK_BYPASS_EN
      if (we && waddr == a) return wdata;
`endif
      return mdl[k][a];
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int i = 0; i < 16; i++) mdl[k][i] <= 32'h0;
            e_rda[k] <= 32'h0; e_rdb[k] <= 32'h0;
            e_rva[k] <= 1'b0;  e_rvb[k] <= 1'b0; e_werr[k] <= 1'b0;
         end else begin
            if (re_a) e_rda[k] <= mread(k, raddr_a);
            if (re_b) e_rdb[k] <= mread(k, raddr_b);
            e_rva[k]  <= re_a;
            e_rvb[k]  <= re_b;
            e_werr[k] <= we && (int'(waddr) >= dep[k]);
            if (we && int'(waddr) < dep[k]) mdl[k][waddr] <= wdata;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model-vs-DUT comparison on every falling edge once out of initial reset.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d_rdata_a", k), o_rda[k], e_rda[k]);
            chk($sformatf("m%0d_rdata_b", k), o_rdb[k], e_rdb[k]);
            chk($sformatf("m%0d_rvalid_a", k), {31'b0, o_rva[k]}, {31'b0, e_rva[k]});
            chk($sformatf("m%0d_rvalid_b", k), {31'b0, o_rvb[k]}, {31'b0, e_rvb[k]});
            chk($sformatf("m%0d_werr", k), {31'b0, o_werr[k]}, {31'b0, e_werr[k]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_rdata_a%0d", tag, k), o_rda[k], 32'h0);
         chk($sformatf("%s_rdata_b%0d", tag, k), o_rdb[k], 32'h0);
         chk($sformatf("%s_rvalid_a%0d", tag, k), {31'b0, o_rva[k]}, 32'h0);
         chk($sformatf("%s_rvalid_b%0d", tag, k), {31'b0, o_rvb[k]}, 32'h0);
         chk($sformatf("%s_werr%0d", tag, k), {31'b0, o_werr[k]}, 32'h0);
      end
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
      waddr = 4'd0; raddr_a = 4'd0; raddr_b = 4'd0; wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      all_zero("reset");
      #2 rst = 1'b0;
      chk_on = 1'b1;

      // Read straight after reset: first edge is accepted, data is 0.
      re_a = 1'b1; raddr_a = 4'd5;
      tick();
      chk("r5_rdata_a0", rda0, 32'h0);
      chk("r5_rvalid_a0", {31'b0, rva0}, 32'h1);
      chk("r5_rdata_a1", rda1, 32'h0);

      // Write then dual-port read of the same register.
      re_a = 1'b0; we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF;
      tick();
      we = 1'b0; re_a = 1'b1; re_b = 1'b1; raddr_a = 4'd3; raddr_b = 4'd3;
      tick();
      chk("w3_rdata_a0", rda0, 32'hDEADBEEF);
      chk("w3_rdata_b0", rdb0, 32'hDEADBEEF);
      chk("w3_rdata_a1", rda1, 32'hDEADBEEF);
      chk("w3_rdata_b1", rdb1, 32'hDEADBEEF);

      // No request: data held, valid drops.
      re_a = 1'b0; re_b = 1'b0;
      tick();
      chk("hold_rdata_a0", rda0, 32'hDEADBEEF);
      chk("hold_rvalid_a0", {31'b0, rva0}, 32'h0);

      // Same-edge collision on register 7.
      we = 1'b1; waddr = 4'd7; wdata = 32'h11;
      tick();
      wdata = 32'h22; re_a = 1'b1; raddr_a = 4'd7;
      tick();
      we = 1'b0;
      chk("coll_rdata_a0", rda0, C_COLL);
      chk("coll_rdata_a1", rda1, C_COLL);
      tick();
      re_a = 1'b0;
      chk("coll_after_a0", rda0, 32'h22);

      // Fill every address; dut1 flags 12..15 as out of range.
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; waddr = 4'(i); wdata = 32'h1000_0000 + 32'h0101_0101 * 32'(i);
         re_b = 1'b1; raddr_b = 4'(i);
         tick();
         if (i == 13) begin
            chk("fill13_werr1", {31'b0, werr1}, 32'h1);
            chk("fill13_werr0", {31'b0, werr0}, 32'h0);
         end
      end

      // Out-of-range write to 13: single-cycle error pulse.
      re_b = 1'b0; we = 1'b1; waddr = 4'd13; wdata = 32'hBAD0BAD0;
      tick();
      we = 1'b0;
      chk("oor_werr1", {31'b0, werr1}, 32'h1);
      tick();
      chk("oor_werr1_clear", {31'b0, werr1}, 32'h0);

      // Read back every address on both ports (model checks contents).
      for (int i = 0; i < 16; i++) begin
         re_a = 1'b1; raddr_a = 4'(i);
         re_b = 1'b1; raddr_b = 4'(15 - i);
         tick();
         if (i == 11) chk("rb11_rdata_a1", rda1, 32'h1B0B_0B0B);
         if (i == 13) begin
            chk("rb13_rdata_a1", rda1, 32'h0);
            chk("rb13_rdata_a0", rda0, 32'hBAD0BAD0);
         end
      end

      // Register 0 on the zero-register instance.
      re_a = 1'b0; re_b = 1'b0; we = 1'b1; waddr = 4'd0; wdata = 32'h0000FFFF;
      tick();
      chk("z0_werr1", {31'b0, werr1}, 32'h0);
      we = 1'b0; re_a = 1'b1; raddr_a = 4'd0;
      tick();
      chk("z0_rdata_a1", rda1, 32'h0);
      chk("z0_rdata_a0", rda0, 32'h0000FFFF);

      // Asynchronous reset in the middle of activity.
      re_a = 1'b0; we = 1'b1; waddr = 4'd9; wdata = 32'hCAFEF00D;
      re_b = 1'b1; raddr_b = 4'd9;
      tick();
      #3 rst = 1'b1;
      #1 all_zero("async_rst");
      @(posedge clk);
      #3 rst = 1'b0;
      we = 1'b0; re_b = 1'b0; re_a = 1'b1; raddr_a = 4'd9;
      tick();
      chk("post_rst_rdata_a0", rda0, 32'h0);
      chk("post_rst_rvalid_a0", {31'b0, rva0}, 32'h1);
      re_a = 1'b0;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regbank_2r1w.md
REGBANK_2R1W -- requirements
Module: regbank_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register, in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of implemented registers, 2..2**ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 4: address width of every port.
REQ-004 SHALL have parameter ZERO_R0, default 0: when 1, register 0 always reads 0 and ignores writes.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port we, input, 1: write enable.
REQ-008 SHALL have port waddr, input, ADDR_W: write address.
REQ-009 SHALL have port wdata, input, WIDTH: write data.
REQ-010 SHALL have port re_a, input, 1: read request on port A.
REQ-011 SHALL have port raddr_a, input, ADDR_W: read address for port A.
REQ-012 SHALL have port rdata_a, output, WIDTH: registered read data for port A.
REQ-013 SHALL have port rvalid_a, output, 1: rdata_a holds the result of a request.
REQ-014 SHALL have ports re_b, raddr_b, rdata_b and rvalid_b, identical to the port A set.
REQ-015 SHALL have port werr, output, 1: one-cycle pulse when a write targets an address >= DEPTH.

Function
REQ-016 SHALL store a write of wdata into register waddr on the rising edge where we=1 and waddr<DEPTH.
REQ-017 SHALL give each read port 1-cycle latency: a request with re_x=1 at edge N updates rdata_x and sets rvalid_x=1 after edge N.
REQ-018 SHALL hold rdata_x when re_x=0, and SHALL clear rvalid_x to 0 after that edge.
REQ-019 SHALL return 0 and set rvalid_x=1 for a read of an address >= DEPTH.
REQ-020 SHALL ignore a write of an address >= DEPTH, leave all registers unchanged, and pulse werr=1 for exactly one cycle.
REQ-021 SHALL, when ZERO_R0=1, return 0 on reads of address 0 and SHALL NOT pulse werr on writes to address 0.
REQ-022 SHALL serve both read ports independently in the same cycle, including reads of the same address.
REQ-023 SHALL resolve a read and a write of the same address at the same edge as defined in REQ-030 and REQ-031.
REQ-024 SHALL generalise the register-select function to any DEPTH and WIDTH with no fixed 16-way decode.

Reset
REQ-025 SHALL, when rst=1, immediately clear all registers to 0, independent of clk.
REQ-026 SHALL, when rst=1, clear rdata_a and rdata_b to 0, clear rvalid_a and rvalid_b to 0, and clear werr to 0.
REQ-027 SHALL ignore we, re_a and re_b while rst=1, including a write or read in progress when rst asserts.
REQ-028 SHALL accept a request at the first rising clk edge after rst deasserts.

Configuration
REQ-029 SHALL use the macro REGBANK_BYPASS_EN to compile write-to-read forwarding in or out.
REQ-030 SHALL, with REGBANK_BYPASS_EN defined, return the wdata written at edge N to a same-edge read of the same valid address (write-first), with ZERO_R0 still taking precedence.
REQ-031 SHALL, without REGBANK_BYPASS_EN, return the pre-write contents to a same-edge read of the same address (read-first).

Verification
REQ-032 SHALL cover reset then read: rst pulse, then re_a=1 with raddr_a=5 -> rdata_a=0 and rvalid_a=1 one cycle later.
REQ-033 SHALL cover write then read: write 0xDEADBEEF to register 3, then read 3 on both ports in the next cycle -> both ports return 0xDEADBEEF one cycle later.
REQ-034 SHALL cover same-cycle collision: register 7 holds 0x11, then write 0x22 to 7 while reading 7 -> 0x22 with REGBANK_BYPASS_EN defined, 0x11 without it.
REQ-035 SHALL cover out-of-range access: DEPTH=12, write to 13 -> werr pulses for 1 cycle and the contents of all 12 registers are unchanged; read of 13 -> 0.
REQ-036 SHALL cover register 0: ZERO_R0=1, write 0xFFFF to 0, then read 0 -> 0, with werr staying 0.
REQ-037 SHALL cover reset mid-operation: assert rst asynchronously between edges while we=1 and re_b=1 -> all outputs go to 0 immediately and the targeted register reads 0 after release.
